// File: rtl/mult_acc_reduce.sv
// Lane-sum, dot-product accumulator and 2-entry result buffer behind the multiplier array.
// Optional accumulator clamping is enabled with `define MULT_ACC_SAT_EN.
module mult_acc_reduce #(
  parameter int NUM_MULTIPLIERS = 128,
  parameter int MUL_LAT         = 3,
  parameter int ACC_W           = 40
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MULTIPLIERS*24-1:0] mul_p,
  input  logic                         in_valid_i,
  input  logic                         in_last_i,
  output logic [ACC_W-1:0]             res_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [15:0]                  beat_cnt_o,
  output logic                         ovf_o,
  output logic                         sat_o
);

  localparam int SUM_W = 24 + $clog2(NUM_MULTIPLIERS);

  typedef enum logic {IDLE, RUN} state_t;

  logic             v_sr [MUL_LAT];
  logic             l_sr [MUL_LAT];
  logic             v_d;
  logic             l_d;
  logic [SUM_W-1:0] lane_sum;
  logic [SUM_W-1:0] lsum;
  logic             lv;
  logic             ll;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] nxt;
  state_t           state;
  state_t           nxt_state;
  logic             push;
  logic             acc_upd;
  logic [ACC_W-1:0] mem [2];
  logic             wp;
  logic             rp;
  logic [1:0]       cnt;
  logic             pop;
  logic             full;
  logic             wr;

  // Re-time operand strobes to the array latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        v_sr[i] <= 1'b0;
        l_sr[i] <= 1'b0;
      end
    end else begin
      v_sr[0] <= in_valid_i;
      l_sr[0] <= in_valid_i & in_last_i;
      for (int i = 1; i < MUL_LAT; i++) begin
        v_sr[i] <= v_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  assign v_d = v_sr[MUL_LAT-1];
  assign l_d = l_sr[MUL_LAT-1];

  // Unsigned sum across all lanes; width is sized so it cannot overflow
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_MULTIPLIERS; i++)
      lane_sum = lane_sum + SUM_W'(mul_p[24*i +: 24]);
  end

  // Stage 1: register the lane sum with its strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lsum <= '0;
      lv   <= 1'b0;
      ll   <= 1'b0;
    end else begin
      lv <= v_d;
      ll <= v_d & l_d;
      if (v_d) lsum <= lane_sum;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt_state;
  end

  // FSM next state
  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE: if (lv && !ll) nxt_state = RUN;
      RUN:  if (lv && ll)  nxt_state = IDLE;
    endcase
  end

  // FSM outputs: a fresh product starts from zero
  always_comb begin
    acc_base = (state == RUN) ? acc : '0;
    push     = lv & ll;
    acc_upd  = lv & ~ll;
  end

`ifdef MULT_ACC_SAT_EN
  logic [ACC_W:0] wide;
  logic           clamp;

  // Saturating add of the lane sum into the accumulator
  always_comb begin
    wide  = {1'b0, acc_base} + {1'b0, ACC_W'(lsum)};
    clamp = wide[ACC_W];
    nxt   = clamp ? '1 : wide[ACC_W-1:0];
  end

  // Sticky saturation flag
  always_ff @(posedge clk_i) begin
    if (rst_i)             sat_o <= 1'b0;
    else if (lv && clamp)  sat_o <= 1'b1;
  end
`else
  assign nxt   = acc_base + ACC_W'(lsum);
  assign sat_o = 1'b0;
`endif

  // Stage 2: accumulator and beat counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc        <= '0;
      beat_cnt_o <= '0;
    end else if (push) begin
      acc        <= '0;
      beat_cnt_o <= '0;
    end else if (acc_upd) begin
      acc <= nxt;
      if (beat_cnt_o != 16'hFFFF) beat_cnt_o <= beat_cnt_o + 16'd1;
    end
  end

  assign pop  = res_valid_o & res_ready_i;
  assign full = (cnt == 2'd2);
  assign wr   = push & (~full | pop);

  // Result FIFO; a pop frees the slot a same-cycle push may reuse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= nxt;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, wr} - {1'b0, pop};
      if (push && full && !pop) ovf_o <= 1'b1;
    end
  end

  assign res_valid_o = (cnt != 2'd0);
  assign res_o       = res_valid_o ? mem[rp] : '0;

endmodule

// File: tb/tb_mult_acc_reduce.sv
// Directed scoreboard bench for mult_acc_reduce.
// Main instance: 4 lanes, latency 3; second instance: 128 lanes, 31-bit accumulator.
module tb_mult_acc_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] p_in;
  logic [95:0] mp_sr [3];
  logic [95:0] mul_p;
  logic        v, l, ready;
  logic [39:0] res;
  logic        res_valid;
  logic [15:0] cnt;
  logic        ovf, sat;

  logic [3071:0] s_mul_p;
  logic          sv, sl, s_ready;
  logic [30:0]   s_res;
  logic          s_valid;
  logic [15:0]   s_cnt;
  logic          s_ovf, s_sat;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int pops = 0;
  logic [39:0] sb [$];

  always #5 clk = ~clk;

  // Stand-in for the multiplier array pipeline
  always_ff @(posedge clk) begin
    mp_sr[0] <= p_in;
    mp_sr[1] <= mp_sr[0];
    mp_sr[2] <= mp_sr[1];
  end
  assign mul_p = mp_sr[2];

  mult_acc_reduce #(.NUM_MULTIPLIERS(4), .MUL_LAT(3), .ACC_W(40)) dut (
    .clk_i(clk), .rst_i(rst), .mul_p(mul_p),
    .in_valid_i(v), .in_last_i(l),
    .res_o(res), .res_valid_o(res_valid), .res_ready_i(ready),
    .beat_cnt_o(cnt), .ovf_o(ovf), .sat_o(sat)
  );

  mult_acc_reduce #(.NUM_MULTIPLIERS(128), .MUL_LAT(3), .ACC_W(31)) dut_s (
    .clk_i(clk), .rst_i(rst), .mul_p(s_mul_p),
    .in_valid_i(sv), .in_last_i(sl),
    .res_o(s_res), .res_valid_o(s_valid), .res_ready_i(s_ready),
    .beat_cnt_o(s_cnt), .ovf_o(s_ovf), .sat_o(s_sat)
  );

  function automatic logic [95:0] lanes4(int a, int b, int c, int d);
    return {24'(d), 24'(c), 24'(b), 24'(a)};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; any handshake seen this cycle is scored against the queue
  task automatic tick();
    logic [39:0] e;
    @(negedge clk);
    if (res_valid && ready) begin
      pops++;
      if (sb.size() == 0) begin
        n_total++;
        n_fail++;
        $error("FAIL sb_extra: observed 0x%0h expected none", res);
      end else begin
        e = sb.pop_front();
        check("sb_res", {24'd0, res}, {24'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic exp_pat [5];
    exp_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; v = 1'b0; l = 1'b0; ready = 1'b0; p_in = '0;
    sv = 1'b0; sl = 1'b0; s_ready = 1'b0; s_mul_p = {128{24'hFFFFFF}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", res_valid, 0);
    check("rst_res", res, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;
    tick();

    // Single beat, lanes {1,2,3,4}
    p_in = lanes4(1, 2, 3, 4); v = 1'b1; l = 1'b1; sb.push_back(40'd10);
    tick();
    v = 1'b0; l = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("single_lat", lat, 5);
    check("single_res", res, 40'd10);
    check("single_cnt", cnt, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("single_sb", sb.size(), 0);

    // Three beats of all-ones lanes
    p_in = lanes4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    v = 1'b1; l = 1'b0;
    tick();
    tick();
    l = 1'b1; sb.push_back(40'hBFFFFF4);
    tick();
    v = 1'b0; l = 1'b0;
    tick();
    tick();
    check("multi_cnt1", cnt, 1);
    tick();
    check("multi_cnt2", cnt, 2);
    tick();
    check("multi_cnt0", cnt, 0);
    check("multi_valid", res_valid, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("multi_sb", sb.size(), 0);

    // Back-to-back products of length 1, 2, 1
    ready = 1'b1;
    p_in = lanes4(1, 1, 1, 1); v = 1'b1; l = 1'b1; sb.push_back(40'd4);
    tick();
    p_in = lanes4(2, 2, 2, 2); l = 1'b0;
    tick();
    p_in = lanes4(3, 3, 3, 3); l = 1'b1; sb.push_back(40'd20);
    tick();
    p_in = lanes4(7, 7, 7, 7); l = 1'b1; sb.push_back(40'd28);
    tick();
    v = 1'b0; l = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b2b_valid%0d", k), res_valid, exp_pat[k]);
      tick();
    end
    check("b2b_ovf", ovf, 0);
    check("b2b_sb", sb.size(), 0);

    // Backpressure: third result overflows the buffer
    ready = 1'b0;
    v = 1'b1; l = 1'b1;
    p_in = lanes4(1, 1, 1, 1); sb.push_back(40'd4);
    tick();
    p_in = lanes4(2, 2, 2, 2); sb.push_back(40'd8);
    tick();
    p_in = lanes4(3, 3, 3, 3);
    tick();
    v = 1'b0; l = 1'b0;
    repeat (8) tick();
    check("bp_ovf", ovf, 1);
    check("bp_valid", res_valid, 1);
    check("bp_head", res, 40'd4);
    pops = 0;
    ready = 1'b1;
    repeat (5) tick();
    check("bp_pops", pops, 2);
    check("bp_sb", sb.size(), 0);
    check("bp_empty", res_valid, 0);
    ready = 1'b0;

    // Reset after 2 of 4 beats
    p_in = lanes4(1, 1, 1, 1); v = 1'b1; l = 1'b0;
    tick();
    tick();
    v = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("rm_valid", res_valid, 0);
    check("rm_res", res, 0);
    check("rm_cnt", cnt, 0);
    check("rm_ovf", ovf, 0);
    check("rm_sat", sat, 0);
    pops = 0;
    ready = 1'b1;
    p_in = lanes4(5, 5, 5, 5); v = 1'b1; l = 1'b1; sb.push_back(40'd20);
    tick();
    v = 1'b0; l = 1'b0;
    repeat (8) tick();
    check("rm_pops", pops, 1);
    check("rm_sb", sb.size(), 0);
    ready = 1'b0;

    // Accumulator overflow on the 128-lane, 31-bit instance
    sv = 1'b1; sl = 1'b0;
    tick();
    sl = 1'b1;
    tick();
    sv = 1'b0; sl = 1'b0;
    repeat (8) tick();
    check("sat_valid", s_valid, 1);
`ifdef MULT_ACC_SAT_EN
    check("sat_res", s_res, 31'h7FFFFFFF);
    check("sat_flag", s_sat, 1);
`else
    check("sat_res", s_res, 31'h7FFFFF00);
    check("sat_flag", s_sat, 0);
`endif
    check("sat_cnt", s_cnt, 0);
    check("sat_ovf", s_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
